// File: rtl/id_ex_latch.sv
// -----------------------------------------------------------------------------
// id_ex_latch
// ID/EX pipeline register for the 5-stage MIPS core. It captures the decoded
// operands and controls, resolves EX/MEM and MEM/WB forwarding, selects the
// ALU operands (register, immediate or shamt) and flags load-use hazards.
//
// Ports
//   i_clk, i_reset        : clock (rising edge), async active-high reset
//   i_stall, i_flush      : hold all state / load a bubble (flush wins)
//   i_valid               : ID holds a real instruction
//   i_rsData, i_rtData    : register-file operands
//   i_imm, i_shamt        : extended immediate, shift amount
//   i_rs, i_rt, i_rd      : register indices (i_rd already muxed by ID)
//   i_aluOp               : ALU opcode
//   i_aluSrcB, i_shiftImm : operand-select controls
//   i_regWrite, i_memRead, i_memWrite, i_memToReg : downstream controls
//   i_exmem*, i_memwb*    : forwarding sources from later stages
//   o_datoA, o_datoB      : ALU operands
//   o_opcode              : ALU opcode
//   o_storeData           : forwarded rt value for stores
//   o_rd, o_regWrite, o_memRead, o_memWrite, o_memToReg, o_valid : EX state
//   o_loadUse             : load-use hazard request
// -----------------------------------------------------------------------------
module id_ex_latch #(
   parameter int N_BITS   = 32,
   parameter int N_OPCODE = 6,
   parameter int N_REG    = 5
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_stall,
   input  logic                i_flush,
   input  logic                i_valid,
   input  logic [N_BITS-1:0]   i_rsData,
   input  logic [N_BITS-1:0]   i_rtData,
   input  logic [N_BITS-1:0]   i_imm,
   input  logic [4:0]          i_shamt,
   input  logic [N_REG-1:0]    i_rs,
   input  logic [N_REG-1:0]    i_rt,
   input  logic [N_REG-1:0]    i_rd,
   input  logic [N_OPCODE-1:0] i_aluOp,
   input  logic                i_aluSrcB,
   input  logic                i_shiftImm,
   input  logic                i_regWrite,
   input  logic                i_memRead,
   input  logic                i_memWrite,
   input  logic                i_memToReg,
   input  logic                i_exmemRegWrite,
   input  logic [N_REG-1:0]    i_exmemRd,
   input  logic [N_BITS-1:0]   i_exmemResult,
   input  logic                i_memwbRegWrite,
   input  logic [N_REG-1:0]    i_memwbRd,
   input  logic [N_BITS-1:0]   i_memwbData,
   output logic [N_BITS-1:0]   o_datoA,
   output logic [N_BITS-1:0]   o_datoB,
   output logic [N_OPCODE-1:0] o_opcode,
   output logic [N_BITS-1:0]   o_storeData,
   output logic [N_REG-1:0]    o_rd,
   output logic                o_regWrite,
   output logic                o_memRead,
   output logic                o_memWrite,
   output logic                o_memToReg,
   output logic                o_valid,
   output logic                o_loadUse
);

   logic                r_valid;
   logic [N_BITS-1:0]   r_rsData;
   logic [N_BITS-1:0]   r_rtData;
   logic [N_BITS-1:0]   r_imm;
   logic [4:0]          r_shamt;
   logic [N_REG-1:0]    r_rs;
   logic [N_REG-1:0]    r_rt;
   logic [N_REG-1:0]    r_rd;
   logic [N_OPCODE-1:0] r_aluOp;
   logic                r_aluSrcB;
   logic                r_shiftImm;
   logic                r_regWrite;
   logic                r_memRead;
   logic                r_memWrite;
   logic                r_memToReg;

   logic [N_BITS-1:0]   w_fwdA;
   logic [N_BITS-1:0]   w_fwdB;
   logic [N_BITS-1:0]   w_datoA;
   logic [N_BITS-1:0]   w_datoB;

   // Pipeline register: reset > flush > stall > load.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_valid    <= 1'b0;
         r_rsData   <= '0;
         r_rtData   <= '0;
         r_imm      <= '0;
         r_shamt    <= 5'd0;
         r_rs       <= '0;
         r_rt       <= '0;
         r_rd       <= '0;
         r_aluOp    <= '0;
         r_aluSrcB  <= 1'b0;
         r_shiftImm <= 1'b0;
         r_regWrite <= 1'b0;
         r_memRead  <= 1'b0;
         r_memWrite <= 1'b0;
         r_memToReg <= 1'b0;
      end else if (i_flush) begin
         r_valid    <= 1'b0;
         r_rsData   <= '0;
         r_rtData   <= '0;
         r_imm      <= '0;
         r_shamt    <= 5'd0;
         r_rs       <= '0;
         r_rt       <= '0;
         r_rd       <= '0;
         r_aluOp    <= '0;
         r_aluSrcB  <= 1'b0;
         r_shiftImm <= 1'b0;
         r_regWrite <= 1'b0;
         r_memRead  <= 1'b0;
         r_memWrite <= 1'b0;
         r_memToReg <= 1'b0;
      end else if (!i_stall) begin
         r_valid    <= i_valid;
         r_rsData   <= i_rsData;
         r_rtData   <= i_rtData;
         r_imm      <= i_imm;
         r_shamt    <= i_shamt;
         r_rs       <= i_rs;
         r_rt       <= i_rt;
         r_rd       <= i_rd;
         r_aluOp    <= i_aluOp;
         r_aluSrcB  <= i_aluSrcB;
         r_shiftImm <= i_shiftImm;
         // Gate controls with valid so a non-instruction can never write state.
         r_regWrite <= i_regWrite & i_valid;
         r_memRead  <= i_memRead  & i_valid;
         r_memWrite <= i_memWrite & i_valid;
         r_memToReg <= i_memToReg & i_valid;
      end else begin
         r_valid    <= r_valid;
         r_rsData   <= r_rsData;
         r_rtData   <= r_rtData;
         r_imm      <= r_imm;
         r_shamt    <= r_shamt;
         r_rs       <= r_rs;
         r_rt       <= r_rt;
         r_rd       <= r_rd;
         r_aluOp    <= r_aluOp;
         r_aluSrcB  <= r_aluSrcB;
         r_shiftImm <= r_shiftImm;
         r_regWrite <= r_regWrite;
         r_memRead  <= r_memRead;
         r_memWrite <= r_memWrite;
         r_memToReg <= r_memToReg;
      end
   end

   // Forwarding: the youngest producer (EX/MEM) wins; register 0 never forwards.
   always_comb begin
      w_fwdA = r_rsData;
      w_fwdB = r_rtData;
      if (i_exmemRegWrite && (i_exmemRd != '0) && (i_exmemRd == r_rs)) begin
         w_fwdA = i_exmemResult;
      end else if (i_memwbRegWrite && (i_memwbRd != '0) && (i_memwbRd == r_rs)) begin
         w_fwdA = i_memwbData;
      end else begin
         w_fwdA = r_rsData;
      end
      if (i_exmemRegWrite && (i_exmemRd != '0) && (i_exmemRd == r_rt)) begin
         w_fwdB = i_exmemResult;
      end else if (i_memwbRegWrite && (i_memwbRd != '0) && (i_memwbRd == r_rt)) begin
         w_fwdB = i_memwbData;
      end else begin
         w_fwdB = r_rtData;
      end
   end

   // Operand select: shift-by-immediate routes rt to A and shamt to B.
   always_comb begin
      w_datoA = w_fwdA;
      w_datoB = w_fwdB;
      if (r_shiftImm) begin
         w_datoA = w_fwdB;
         w_datoB = {{(N_BITS-5){1'b0}}, r_shamt};
      end else if (r_aluSrcB) begin
         w_datoA = w_fwdA;
         w_datoB = r_imm;
      end else begin
         w_datoA = w_fwdA;
         w_datoB = w_fwdB;
      end
   end

   assign o_datoA     = w_datoA;
   assign o_datoB     = w_datoB;
   assign o_storeData = w_fwdB;
   assign o_opcode    = r_aluOp;
   assign o_rd        = r_rd;
   assign o_regWrite  = r_regWrite;
   assign o_memRead   = r_memRead;
   assign o_memWrite  = r_memWrite;
   assign o_memToReg  = r_memToReg;
   assign o_valid     = r_valid;

   // A load in EX whose destination is read by the instruction now in ID.
   assign o_loadUse = r_valid & r_memRead & (r_rd != '0) &
                      ((r_rd == i_rs) | (r_rd == i_rt));

endmodule

// File: tb/tb_id_ex_latch.sv
module tb_id_ex_latch;

   logic        i_clk = 1'b0;
   logic        i_reset, i_stall, i_flush, i_valid;
   logic [31:0] i_rsData, i_rtData, i_imm;
   logic [4:0]  i_shamt, i_rs, i_rt, i_rd;
   logic [5:0]  i_aluOp;
   logic        i_aluSrcB, i_shiftImm, i_regWrite, i_memRead, i_memWrite, i_memToReg;
   logic        i_exmemRegWrite, i_memwbRegWrite;
   logic [4:0]  i_exmemRd, i_memwbRd;
   logic [31:0] i_exmemResult, i_memwbData;
   logic [31:0] o_datoA, o_datoB, o_storeData;
   logic [5:0]  o_opcode;
   logic [4:0]  o_rd;
   logic        o_regWrite, o_memRead, o_memWrite, o_memToReg, o_valid, o_loadUse;

   int n_cmp  = 0;
   int n_fail = 0;

   // Instruction record as it should sit in EX.
   typedef struct {
      bit        valid;
      bit [31:0] rsd, rtd, imm;
      bit [4:0]  shamt, rs, rt, rd;
      bit [5:0]  op;
      bit        srcb, shimm, rw, mr, mw, m2r;
   } instr_t;

   instr_t ex;

   id_ex_latch dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall), .i_flush(i_flush),
      .i_valid(i_valid), .i_rsData(i_rsData), .i_rtData(i_rtData), .i_imm(i_imm),
      .i_shamt(i_shamt), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_aluOp(i_aluOp),
      .i_aluSrcB(i_aluSrcB), .i_shiftImm(i_shiftImm), .i_regWrite(i_regWrite),
      .i_memRead(i_memRead), .i_memWrite(i_memWrite), .i_memToReg(i_memToReg),
      .i_exmemRegWrite(i_exmemRegWrite), .i_exmemRd(i_exmemRd),
      .i_exmemResult(i_exmemResult), .i_memwbRegWrite(i_memwbRegWrite),
      .i_memwbRd(i_memwbRd), .i_memwbData(i_memwbData),
      .o_datoA(o_datoA), .o_datoB(o_datoB), .o_opcode(o_opcode),
      .o_storeData(o_storeData), .o_rd(o_rd), .o_regWrite(o_regWrite),
      .o_memRead(o_memRead), .o_memWrite(o_memWrite), .o_memToReg(o_memToReg),
      .o_valid(o_valid), .o_loadUse(o_loadUse)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic instr_t empty_instr();
      instr_t e;
      e.valid = 0; e.rsd = 0; e.rtd = 0; e.imm = 0; e.shamt = 0; e.rs = 0; e.rt = 0;
      e.rd = 0; e.op = 0; e.srcb = 0; e.shimm = 0; e.rw = 0; e.mr = 0; e.mw = 0; e.m2r = 0;
      return e;
   endfunction

   // Value a register read sees after consulting the later pipeline stages.
   function automatic bit [31:0] resolve(input bit [4:0] idx, input bit [31:0] file_val);
      if (idx == 0) return file_val;
      if (i_exmemRegWrite && i_exmemRd == idx) return i_exmemResult;
      if (i_memwbRegWrite && i_memwbRd == idx) return i_memwbData;
      return file_val;
   endfunction

   // Model clock edge: reset > flush > stall > load.
   task automatic tick();
      @(posedge i_clk);
      if (i_reset || i_flush) ex = empty_instr();
      else if (!i_stall) begin
         ex.valid = i_valid; ex.rsd = i_rsData; ex.rtd = i_rtData; ex.imm = i_imm;
         ex.shamt = i_shamt; ex.rs = i_rs; ex.rt = i_rt; ex.rd = i_rd; ex.op = i_aluOp;
         ex.srcb = i_aluSrcB; ex.shimm = i_shiftImm;
         ex.rw = i_valid && i_regWrite; ex.mr = i_valid && i_memRead;
         ex.mw = i_valid && i_memWrite; ex.m2r = i_valid && i_memToReg;
      end
      #1;
   endtask

   task automatic check_model(input string tag);
      bit [31:0] a, b, st;
      bit lu;
      st = resolve(ex.rt, ex.rtd);
      if (ex.shimm) begin a = st; b = 32'(ex.shamt); end
      else begin a = resolve(ex.rs, ex.rsd); b = ex.srcb ? ex.imm : st; end
      lu = ex.valid && ex.mr && ex.rd != 0 && (ex.rd == i_rs || ex.rd == i_rt);
      chk({tag, ".A"},   o_datoA, a);
      chk({tag, ".B"},   o_datoB, b);
      chk({tag, ".st"},  o_storeData, st);
      chk({tag, ".op"},  32'(o_opcode), 32'(ex.op));
      chk({tag, ".rd"},  32'(o_rd), 32'(ex.rd));
      chk({tag, ".ctl"}, {27'd0, o_valid, o_regWrite, o_memRead, o_memWrite, o_memToReg},
          {27'd0, ex.valid, ex.rw, ex.mr, ex.mw, ex.m2r});
      chk({tag, ".lu"},  32'(o_loadUse), 32'(lu));
   endtask

   task automatic idle_inputs();
      i_stall = 0; i_flush = 0; i_valid = 0; i_rsData = 0; i_rtData = 0; i_imm = 0;
      i_shamt = 0; i_rs = 0; i_rt = 0; i_rd = 0; i_aluOp = 0; i_aluSrcB = 0;
      i_shiftImm = 0; i_regWrite = 0; i_memRead = 0; i_memWrite = 0; i_memToReg = 0;
      i_exmemRegWrite = 0; i_exmemRd = 0; i_exmemResult = 0;
      i_memwbRegWrite = 0; i_memwbRd = 0; i_memwbData = 0;
   endtask

   initial begin
      ex = empty_instr();
      idle_inputs();
      i_reset = 1;
      #1;
      check_model("reset0");
      tick();
      i_reset = 0;

      // Plain capture of ADD 5, 3.
      i_valid = 1; i_rsData = 32'h5; i_rtData = 32'h3; i_aluOp = 6'b000010;
      i_rs = 5'd1; i_rt = 5'd2; i_rd = 5'd3; i_regWrite = 1;
      tick();
      chk("add.A", o_datoA, 32'h5);
      chk("add.B", o_datoB, 32'h3);
      chk("add.op", 32'(o_opcode), 32'h2);
      chk("add.valid", 32'(o_valid), 32'h1);
      check_model("add");

      // Mid-cycle reset clears the outputs before the next edge.
      #2 i_reset = 1;
      #1;
      ex = empty_instr();
      chk("rst.A", o_datoA, 32'h0);
      chk("rst.valid", 32'(o_valid), 32'h0);
      chk("rst.lu", 32'(o_loadUse), 32'h0);
      check_model("rst");
      #1 i_reset = 0;

      // Forwarding priority with rs = rt = 8.
      i_rs = 5'd8; i_rt = 5'd8; i_rsData = 32'hAAAA0000; i_rtData = 32'hBBBB0000;
      tick();
      i_exmemRegWrite = 1; i_exmemRd = 5'd8; i_exmemResult = 32'h11111111;
      i_memwbRegWrite = 1; i_memwbRd = 5'd8; i_memwbData = 32'h22222222;
      #1;
      chk("fwd.ex.A", o_datoA, 32'h11111111);
      chk("fwd.ex.B", o_datoB, 32'h11111111);
      i_exmemRegWrite = 0;
      #1;
      chk("fwd.wb.A", o_datoA, 32'h22222222);
      chk("fwd.wb.B", o_datoB, 32'h22222222);
      i_exmemRegWrite = 1; i_exmemRd = 5'd0; i_memwbRd = 5'd0;
      #1;
      chk("fwd.r0.A", o_datoA, 32'hAAAA0000);
      chk("fwd.r0.B", o_datoB, 32'hBBBB0000);
      check_model("fwd");
      i_exmemRegWrite = 0; i_memwbRegWrite = 0;

      // Shift immediate overrides aluSrcB.
      i_aluOp = 6'b000000; i_shiftImm = 1; i_rtData = 32'hF; i_shamt = 5'd4;
      i_aluSrcB = 1; i_imm = 32'hDEAD; i_rt = 5'd4;
      tick();
      chk("sll.A", o_datoA, 32'hF);
      chk("sll.B", o_datoB, 32'h4);
      i_shiftImm = 0; i_aluSrcB = 0;

      // Load-use, then flush+stall bubble.
      i_aluOp = 6'b000010; i_memRead = 1; i_memToReg = 1; i_rd = 5'd9; i_rt = 5'd1;
      tick();
      i_memRead = 0; i_memToReg = 0; i_rt = 5'd9;
      #1;
      chk("lu.hit", 32'(o_loadUse), 32'h1);
      i_flush = 1; i_stall = 1;
      tick();
      chk("lu.valid", 32'(o_valid), 32'h0);
      chk("lu.rw", 32'(o_regWrite), 32'h0);
      chk("lu.op", 32'(o_opcode), 32'h0);
      chk("lu.clear", 32'(o_loadUse), 32'h0);
      i_flush = 0; i_stall = 0;

      // Stall holds a LUI for three cycles while ID inputs churn.
      i_aluOp = 6'b001111; i_imm = 32'h00001234; i_aluSrcB = 1; i_rd = 5'd5;
      tick();
      i_stall = 1;
      for (int k = 0; k < 3; k++) begin
         i_imm = $urandom; i_aluOp = 6'($urandom); i_aluSrcB = 1'($urandom);
         i_valid = 1'($urandom);
         tick();
         chk("stall.B", o_datoB, 32'h00001234);
         chk("stall.op", 32'(o_opcode), 32'h0F);
      end
      i_stall = 0;

      // Randomized traffic against the model.
      for (int n = 0; n < 300; n++) begin
         i_valid = 1'($urandom); i_rsData = $urandom; i_rtData = $urandom; i_imm = $urandom;
         i_shamt = 5'($urandom); i_rs = 5'($urandom_range(0, 3)); i_rt = 5'($urandom_range(0, 3));
         i_rd = 5'($urandom_range(0, 3)); i_aluOp = 6'($urandom);
         i_aluSrcB = 1'($urandom); i_shiftImm = ($urandom_range(0, 3) == 0);
         i_regWrite = 1'($urandom); i_memRead = 1'($urandom);
         i_memWrite = 1'($urandom); i_memToReg = 1'($urandom);
         i_stall = ($urandom_range(0, 5) == 0); i_flush = ($urandom_range(0, 7) == 0);
         i_exmemRegWrite = 1'($urandom); i_exmemRd = 5'($urandom_range(0, 3));
         i_exmemResult = $urandom;
         i_memwbRegWrite = 1'($urandom); i_memwbRd = 5'($urandom_range(0, 3));
         i_memwbData = $urandom;
         #1;
         check_model("rnd");
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
